// File: rtl/csr_file_if.sv
// csr_file_if: CSR command/address/data bundle between the pipeline and csr_file
interface csr_file_if;
   logic [2:0]  csr_cmd;
   logic [11:0] csr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_stall;
   logic        csr_read_illegal;
   logic        csr_write_illegal;
   logic        csr_system_illegal;
   modport master (
      output csr_cmd, csr, csr_wdata,
      input  csr_rdata, csr_stall, csr_read_illegal, csr_write_illegal, csr_system_illegal
   );
   modport slave (
      input  csr_cmd, csr, csr_wdata,
      output csr_rdata, csr_stall, csr_read_illegal, csr_write_illegal, csr_system_illegal
   );
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with mcycle counter; CSR_USER_COUNTERS_EN adds read-only cycle/time aliases
module csr_file #(
   parameter logic [31:0] HART_ID  = 32'd0,
   parameter logic [31:0] MISA_VAL = 32'h40000100
) (
   input logic       clk,
   input logic       reset,
   csr_file_if.slave bus
);
   localparam logic [2:0] CMD_W = 3'd1;
   localparam logic [2:0] CMD_S = 3'd2;
   localparam logic [2:0] CMD_C = 3'd3;
   localparam logic [2:0] CMD_I = 3'd4;
   logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
   logic [2:0]  mie_q, mie_d;
   logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
   logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [31:0] rdata, nv;
   logic        impl, wr, ri, wi, si, we, mret;
   // address decode: pre-update read value and whether the address exists
   always_comb begin
      rdata = '0;
      impl  = 1'b1;
      case (bus.csr)
         12'h300: rdata = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
         12'h301: rdata = MISA_VAL;
         12'h304: rdata = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
         12'h305: rdata = {mtvec_q, 2'b00};
         12'h340: rdata = mscratch_q;
         12'h341: rdata = {mepc_q, 2'b00};
         12'h342: rdata = mcause_q;
         12'h343: rdata = mtval_q;
         12'h344: rdata = '0;
         12'hB00: rdata = mcycle_q[31:0];
         12'hB80: rdata = mcycle_q[63:32];
         12'hF14: rdata = HART_ID;
`ifdef CSR_USER_COUNTERS_EN
         12'hC00, 12'hC01: rdata = mcycle_q[31:0];
         12'hC80, 12'hC81: rdata = mcycle_q[63:32];
`endif
         default: impl = 1'b0;
      endcase
   end
   // read-modify-write value, legality flags and next state
   always_comb begin
      nv   = bus.csr_cmd == CMD_W ? bus.csr_wdata :
             bus.csr_cmd == CMD_S ? rdata | bus.csr_wdata : rdata & ~bus.csr_wdata;
      wr   = bus.csr_cmd == CMD_W ||
             ((bus.csr_cmd == CMD_S || bus.csr_cmd == CMD_C) && |bus.csr_wdata);
      ri   = (bus.csr_cmd == CMD_W || bus.csr_cmd == CMD_S || bus.csr_cmd == CMD_C) && !impl;
      wi   = wr && bus.csr[11:10] == 2'b11;
      si   = (bus.csr_cmd == CMD_I && !(bus.csr == 12'h000 || bus.csr == 12'h001 || bus.csr == 12'h302))
             || bus.csr_cmd > CMD_I;
      we   = wr && !ri && !wi;
      mret = bus.csr_cmd == CMD_I && bus.csr == 12'h302;
      mst_mie_d  = mret ? mst_mpie_q : (we && bus.csr == 12'h300) ? nv[3] : mst_mie_q;
      mst_mpie_d = mret ? 1'b1 : (we && bus.csr == 12'h300) ? nv[7] : mst_mpie_q;
      mie_d      = (we && bus.csr == 12'h304) ? {nv[11], nv[7], nv[3]} : mie_q;
      mtvec_d    = (we && bus.csr == 12'h305) ? nv[31:2] : mtvec_q;
      mscratch_d = (we && bus.csr == 12'h340) ? nv : mscratch_q;
      mepc_d     = (we && bus.csr == 12'h341) ? nv[31:2] : mepc_q;
      mcause_d   = (we && bus.csr == 12'h342) ? nv : mcause_q;
      mtval_d    = (we && bus.csr == 12'h343) ? nv : mtval_q;
      mcycle_d   = (we && bus.csr == 12'hB00) ? {mcycle_q[63:32], nv} :
                   (we && bus.csr == 12'hB80) ? {nv, mcycle_q[31:0]} : mcycle_q + 64'd1;
      bus.csr_rdata          = rdata;
      bus.csr_stall          = 1'b0;
      bus.csr_read_illegal   = ri;
      bus.csr_write_illegal  = wi;
      bus.csr_system_illegal = si;
   end
   // state commit; reset wins over any concurrent write
   always_ff @(posedge clk) begin
      if (reset) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
      end
   end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboard bench for csr_file; flags compared as {stall, read_ill, write_ill, system_ill}
module tb_csr_file;
   localparam logic [3:0] F0 = 4'b0000, RI = 4'b0100, WI = 4'b0010, SI = 4'b0001;
   typedef struct {
      string       tag;
      logic        chk_rd;
      logic [31:0] rd;
      logic [3:0]  fl;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0, n_fail = 0;
   exp_t sb[$];
   csr_file_if bus();
   csr_file #(.HART_ID(32'd7)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // drive one cycle of stimulus and queue what the DUT must show during it
   task automatic drive(input string tag, input logic [2:0] c, input logic [11:0] a,
                        input logic [31:0] d, input logic chk_rd, input logic [31:0] rd,
                        input logic [3:0] fl);
      exp_t e;
      bus.csr_cmd   = c;
      bus.csr       = a;
      bus.csr_wdata = d;
      e.tag = tag; e.chk_rd = chk_rd; e.rd = rd; e.fl = fl;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (e.chk_rd) check({e.tag, "_rd"}, bus.csr_rdata, e.rd);
         check({e.tag, "_fl"}, {28'd0, bus.csr_stall, bus.csr_read_illegal,
               bus.csr_write_illegal, bus.csr_system_illegal}, {28'd0, e.fl});
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
   initial begin
      bus.csr_cmd = 3'd0; bus.csr = '0; bus.csr_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      drive("rst_mcycle",  3'd0, 12'hB00, 0, 1, 32'd0, F0);
      drive("rst_mstatus", 3'd0, 12'h300, 0, 1, 32'h1800, F0);
      drive("rst_mscratch",3'd0, 12'h340, 0, 1, 32'd0, F0);
      drive("w_scr",       3'd1, 12'h340, 32'hDEADBEEF, 1, 32'd0, F0);
      drive("r_scr",       3'd0, 12'h340, 0, 1, 32'hDEADBEEF, F0);
      drive("w_scr2",      3'd1, 12'h340, 32'hF0F0F0F0, 1, 32'hDEADBEEF, F0);
      drive("s_scr",       3'd2, 12'h340, 32'h0000000F, 1, 32'hF0F0F0F0, F0);
      drive("c_scr",       3'd3, 12'h340, 32'hF0000000, 1, 32'hF0F0F0FF, F0);
      drive("r_scr2",      3'd0, 12'h340, 0, 1, 32'h00F0F0FF, F0);
      drive("s0_scr",      3'd2, 12'h340, 0, 1, 32'h00F0F0FF, F0);
      drive("w_hart",      3'd1, 12'hF14, 32'd5, 1, 32'd7, WI);
      drive("s0_hart",     3'd2, 12'hF14, 0, 1, 32'd7, F0);
      drive("w_unimpl",    3'd1, 12'h7FF, 32'd1, 1, 32'd0, RI);
      drive("sys_bad",     3'd4, 12'h123, 0, 1, 32'd0, SI);
      drive("ecall",       3'd4, 12'h000, 0, 1, 32'd0, F0);
      drive("ebreak",      3'd4, 12'h001, 0, 1, 32'd0, F0);
      drive("cmd5",        3'd5, 12'h340, 0, 1, 32'h00F0F0FF, SI);
      drive("cmd7",        3'd7, 12'h300, 0, 1, 32'h1800, SI);
      drive("w_mstatus",   3'd1, 12'h300, 32'h80, 1, 32'h1800, F0);
      drive("r_mstatus",   3'd0, 12'h300, 0, 1, 32'h1880, F0);
      drive("mret",        3'd4, 12'h302, 0, 1, 32'd0, F0);
      drive("r_mret",      3'd0, 12'h300, 0, 1, 32'h1888, F0);
      drive("w_mie",       3'd1, 12'h304, 32'hFFFFFFFF, 1, 32'd0, F0);
      drive("r_mie",       3'd0, 12'h304, 0, 1, 32'h888, F0);
      drive("w_mtvec",     3'd1, 12'h305, 32'hFFFFFFFF, 1, 32'd0, F0);
      drive("r_mtvec",     3'd0, 12'h305, 0, 1, 32'hFFFFFFFC, F0);
      drive("w_mepc",      3'd1, 12'h341, 32'h12345677, 1, 32'd0, F0);
      drive("r_mepc",      3'd0, 12'h341, 0, 1, 32'h12345674, F0);
      drive("w_mcause",    3'd1, 12'h342, 32'h8000000B, 1, 32'd0, F0);
      drive("r_mcause",    3'd0, 12'h342, 0, 1, 32'h8000000B, F0);
      drive("w_mtval",     3'd1, 12'h343, 32'hCAFEF00D, 1, 32'd0, F0);
      drive("r_mtval",     3'd0, 12'h343, 0, 1, 32'hCAFEF00D, F0);
      drive("w_misa",      3'd1, 12'h301, 32'd0, 1, 32'h40000100, F0);
      drive("r_misa",      3'd0, 12'h301, 0, 1, 32'h40000100, F0);
      drive("w_mip",       3'd1, 12'h344, 32'hFFFFFFFF, 1, 32'd0, F0);
      drive("r_mip",       3'd0, 12'h344, 0, 1, 32'd0, F0);
      drive("w_mcych",     3'd1, 12'hB80, 32'd0, 0, 32'd0, F0);
      drive("w_mcyc",      3'd1, 12'hB00, 32'd100, 0, 32'd0, F0);
      drive("r_mcyc0",     3'd0, 12'hB00, 0, 1, 32'd100, F0);
      drive("r_mcyc1",     3'd0, 12'hB00, 0, 1, 32'd101, F0);
      drive("r_mcych",     3'd0, 12'hB80, 0, 1, 32'd0, F0);
`ifdef CSR_USER_COUNTERS_EN
      drive("r_cycle",     3'd0, 12'hC00, 0, 1, 32'd103, F0);
      drive("w_cycle",     3'd1, 12'hC00, 32'd5, 1, 32'd104, WI);
      drive("r_cyc_held",  3'd0, 12'hB00, 0, 1, 32'd105, F0);
      drive("r_timeh",     3'd0, 12'hC81, 0, 1, 32'd0, F0);
`else
      drive("r_cycle",     3'd0, 12'hC00, 0, 1, 32'd0, F0);
      drive("w_cycle",     3'd1, 12'hC00, 32'd5, 1, 32'd0, RI | WI);
      drive("s_time",      3'd2, 12'hC01, 32'd0, 1, 32'd0, RI);
`endif
      drive("w_wrap_lo",   3'd1, 12'hB00, 32'hFFFFFFFF, 0, 32'd0, F0);
      drive("w_wrap_hi",   3'd1, 12'hB80, 32'd0, 0, 32'd0, F0);
      drive("r_wrap_lo0",  3'd0, 12'hB00, 0, 1, 32'hFFFFFFFF, F0);
      drive("r_wrap_lo1",  3'd0, 12'hB00, 0, 1, 32'd0, F0);
      drive("r_wrap_hi",   3'd0, 12'hB80, 0, 1, 32'd1, F0);
      reset = 1'b1;
      bus.csr_cmd = 3'd1; bus.csr = 12'h340; bus.csr_wdata = 32'hAAAA5555;
      @(posedge clk);
      #1 reset = 1'b0;
      drive("rst2_mcycle", 3'd0, 12'hB00, 0, 1, 32'd0, F0);
      drive("rst2_scr",    3'd0, 12'h340, 0, 1, 32'd0, F0);
      drive("rst2_mstat",  3'd0, 12'h300, 0, 1, 32'h1800, F0);
      bus.csr_cmd = 3'd0;
      @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
